// File: rtl/uart_frame_tx.sv
// Byte-wide UART transmitter: one-word holding register feeding a start/data/parity/stop
// serialiser timed by an internal baud counter. tx_o idles high.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold_reg;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_bit;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;

  logic baud_wrap;
  logic stop_done;
  logic load_now;
  logic accept;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign stop_done = (state == STOP) && baud_wrap && (bit_cnt == STOP_LAST);
  assign load_now  = hold_full && ((state == IDLE) || stop_done);

  // The holding register empties on a load edge, so a byte offered on that
  // same edge is taken even though ready is still low during that cycle.
  assign accept = send && (!hold_full || load_now);
  assign ready  = !hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= data;
      hold_full <= 1'b1;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shifter    <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_o       <= 1'b1;
      busy       <= 1'b0;
    end else begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx_o     <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (hold_full) begin
            shifter    <= hold_reg;
            parity_bit <= (^hold_reg) ^ ODD_BIT;
            state      <= START;
            tx_o       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            state   <= DATA;
            tx_o    <= shifter[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_o  <= parity_bit;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              shifter <= shifter >> 1;
              tx_o    <= shifter[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (baud_wrap) begin
            state   <= STOP;
            tx_o    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              // A byte already waiting starts its frame with no idle gap.
              if (hold_full) begin
                shifter    <= hold_reg;
                parity_bit <= (^hold_reg) ^ ODD_BIT;
                state      <= START;
                tx_o       <= 1'b0;
              end else begin
                state <= IDLE;
                tx_o  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Byte-oriented UART transmitter: the transmit-side counterpart of `uart_receive` on the same serial link. It accepts bytes over a `send`/`ready` handshake into a one-word holding register and serialises each one on `tx_o`. The line format is 1 start bit (0), DATA_BITS data bits LSB first, an optional parity bit, and 1 or 2 stop bits (1). Bit timing comes from an internal baud counter driven by the system clock, so no external divided clock is needed.

## Interface
- CLKS_PER_BIT, default 16: `clk` cycles per serial bit; legal values are ≥ 2.
- DATA_BITS, default 8: data bits per frame; legal range 5–8.
- PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN = 0.
- STOP_BITS, default 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- data  in  DATA_BITS  byte to send; sampled only on an accepting edge.
- send  in  1  request to send; level-sensitive, qualified by `ready`.
- ready  out  1  holding register is empty, so a new byte can be accepted.
- busy  out  1  a frame is being shifted out on `tx_o`.
- tx_o  out  1  serial line, registered; idles high.

## Operation
- Reset values: `tx_o` = 1, `ready` = 1, `busy` = 0. Reset also clears the holding register, the shifter, the baud counter and the bit counter, and puts the FSM in IDLE.
- Accept: on a rising edge where `send` = 1 and `ready` = 1, capture `data` into the holding register and set hold_full, so `ready` = 0.
- If `send` = 1 while `ready` = 0, the request is ignored: no capture, no error flag.
- FSM states and transitions:
  - IDLE: `tx_o` = 1. If hold_full, move the holding register into the shifter, clear hold_full (`ready` = 1), reset the baud counter, go to START.
  - START: `tx_o` = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shifter bit 0, shift right each bit period. After DATA_BITS bits, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
  - PARITY: drive the XOR of the data bits (even parity); for odd parity, drive its inverse. Lasts one bit period, then go to STOP.
  - STOP: `tx_o` = 1 for STOP_BITS × CLKS_PER_BIT cycles. At the end:
    - if hold_full, load the shifter and go directly to START;
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT−1 and wraps; a bit-period boundary occurs at the wrap. Its width is clog2(CLKS_PER_BIT). The bit counter is wide enough to count DATA_BITS.
- `busy` = 1 in every state except IDLE.
- Simultaneous events: an accept can happen on the same edge as a shifter load from the holding register. The old holding value goes to the shifter and the new byte is captured, so hold_full stays 1.
- Reset mid-frame: the frame is abandoned, `tx_o` returns high asynchronously, and any pending byte is discarded.

## Timing
- Accept at edge N gives:
  - `ready` = 0 after edge N;
  - if the FSM was IDLE, after edge N+1: state START, `tx_o` = 0, `busy` = 1, `ready` = 1.
- Latency from accept to the falling edge of the start bit on `tx_o` is exactly 1 clock, from IDLE.
- Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles. With the defaults that is 160 cycles.
- Back-to-back frames: if the next byte is held by the last cycle of the stop period, the next start bit begins on the following cycle. There are zero idle cycles between frames.
- `busy` falls on the same edge on which `tx_o` holds its final idle 1 and the state enters IDLE.
- Sustained throughput is one byte per frame length. `ready` is high for most of each frame, so the producer gets a full frame time to supply the next byte.

## Test plan
- Defaults, send 0xA5 from idle:
  - `tx_o` bit sequence is 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit exactly 16 cycles;
  - `busy` is high for 160 cycles;
  - `ready` is low for exactly 1 cycle.
- Back-to-back 0x00 then 0xFF, with the second send issued while the first frame is busy:
  - the second start bit immediately follows the first stop bit;
  - no idle-high gap beyond the stop period;
  - the total is 320 cycles of `busy`.
- Overrun: three sends on consecutive cycles with 0x11, 0x22, 0x33:
  - 0x11 and 0x22 are transmitted;
  - 0x33 is accepted only when `ready` returns high, and is dropped if `send` was not held.
- PARITY_EN = 1, PARITY_ODD = 1, send 0x07: parity bit = 0, and the frame is 11 bit periods. With even parity, the same byte gives parity bit = 1.
- STOP_BITS = 2, CLKS_PER_BIT = 4, send 0x80: stop high for 8 cycles, and the frame is 44 cycles.
- Reset mid-frame, asserted during data bit 3: `tx_o` = 1, `busy` = 0, `ready` = 1 immediately. After release, a new 0x3C is sent as a complete, correct frame.
